fetch_stage: RTL
================

# fetch_stage

Instruction fetch unit for the XM23 pipeline: owns the program counter, reads instruction words from instruction memory over a single-outstanding req/ack handshake, and buffers them in a 2-entry queue. It presents them to `decode_stage` as `inst` / `inst_pc` / `inst_valid`, so decode is no longer driven by a constant instruction. Branch/exception redirects flush the queue and discard any in-flight read.

## Interface
- `RESET_PC`, default 16'h0000: PC loaded on reset; bit 0 ignored.
- `QDEPTH`, default 2: instruction queue entries; power of two, ≥ 2.
- `clk_in`  in  1: pipeline clock. Already decided.
- `reset`  in  1: asynchronous, active-high. Already decided.
- `stall`  in  1: decode cannot accept this cycle; head entry is held.
- `redirect`  in  1: load a new PC and flush all fetched state.
- `redirect_pc`  in  16: target byte address; bit 0 forced to 0.
- `mem_req`  out  1: read request, registered.
- `mem_addr`  out  16: word-aligned read address, registered; stable while `mem_req` is high.
- `mem_ack`  in  1: read complete this cycle; only meaningful while `mem_req` is high.
- `mem_rdata`  in  16: instruction word; valid in the `mem_ack` cycle.
- `inst`  out  16: head instruction; 16'h0000 when `inst_valid` is 0.
- `inst_pc`  out  16: byte address of `inst`; 16'h0000 when invalid.
- `inst_valid`  out  1: queue non-empty.

## Operation
- Registers:
  - `pc`: next address to request.
  - Queue of {addr, data} pairs with a count.
  - FSM state.
- FSM states:
  - IDLE: no request outstanding.
  - WAIT: request outstanding, data will be kept.
  - DISCARD: request outstanding, data will be dropped.
- IDLE → WAIT: at an edge where `count_next < QDEPTH`, set `mem_req`=1, `mem_addr`=`pc`, `pc`+=2. `count_next` includes this edge's pop.
- WAIT with `mem_ack`:
  - Push {`mem_addr`, `mem_rdata`}.
  - If `count_next < QDEPTH` (push and pop included), issue the next request on the same edge and stay in WAIT; `mem_req` stays high with the new address.
  - Otherwise drop `mem_req` and go to IDLE.
- Issuing only when a free slot exists reserves that slot, so a push never overflows.
- Pop: an edge with `inst_valid`=1 and `stall`=0.
- Simultaneous push and pop: count unchanged, order preserved.
- `redirect` has priority over pop, push and issue at that edge:
  - Queue flushed (count=0) and `pc`=`redirect_pc`.
  - From IDLE: the new request issues on the same edge at `redirect_pc`; `pc` becomes `redirect_pc`+2.
  - From WAIT without ack: go to DISCARD. `mem_req`/`mem_addr` stay unchanged, because a request is never aborted.
  - From WAIT with ack in the same cycle: the data is dropped and the new request issues as from IDLE.
- DISCARD with `mem_ack`: data dropped; issue at `pc` on the same edge and go to WAIT.
- `redirect` while in DISCARD: update `pc` only; stay in DISCARD.
- PC wraps 16'hFFFE → 16'h0000 silently.
- `mem_ack` while `mem_req`=0 is ignored.

## Timing
- Reset (async):
  - `mem_req`=0, `mem_addr`=`RESET_PC`, `pc`=`RESET_PC`.
  - Queue empty; `inst_valid`=0, `inst`=0, `inst_pc`=0.
  - State IDLE.
- Reset asserted mid-WAIT: the request is abandoned and nothing is pushed. The memory is reset by the same signal.
- First request: `mem_req` rises on the first `clk_in` edge after reset deasserts.
- Latency: data acked at edge N is visible on `inst` after edge N (registered queue).
- With a zero-wait memory (ack in every `mem_req` cycle) and `stall`=0, throughput is one instruction per cycle.
- `inst` / `inst_pc` / `inst_valid` are driven directly from queue registers, with no combinational path from `stall` or `mem_ack`.
- After a redirect edge, `inst_valid`=0 for at least one cycle.

## Structure
- `xm23_pkg` holds:
  - `fetch_state_t` enum {IDLE, WAIT, DISCARD}.
  - `INST_W`=16, `ADDR_W`=16, `PC_STEP`=2.
- Sub-module `inst_queue`:
  - Parameterized FIFO with a synchronous flush.
  - Push and pop in the same cycle.
  - Exposes head data/addr and count.
- `fetch_stage` instantiates `inst_queue` and contains the FSM and PC logic.

## Test plan
- Reset release, zero-wait memory returning `mem_addr`^16'hA5A5, `stall`=0 → `mem_req` high from the first edge; `inst_pc` sequence 0,2,4,6 on consecutive cycles with matching data.
- `stall`=1 from the start → exactly 2 requests (0, 2), then `mem_req`=0. Releasing `stall` for one cycle pops addr 0 and issues addr 4 on that edge.
- Memory with 3-cycle ack latency → `mem_addr` stable and `mem_req` high for 3 cycles; throughput is 1 instruction per 3 cycles.
- `redirect` to 16'h0100 in IDLE with a full queue → next cycle `inst_valid`=0 and `mem_addr`=16'h0100. The first delivered `inst_pc` is 16'h0100, then 16'h0102.
- `redirect` to 16'h0200 one cycle into a 3-cycle read of addr 4 → addr 4 held until ack; its data is never seen on `inst`. The next request is 16'h0200. A second redirect to 16'h0300 during DISCARD → request 16'h0300 instead.
- Reset asserted during WAIT, then released → outputs at reset values immediately; refetch starts at `RESET_PC`; stale ack data never appears.

Source files
------------

// File: rtl/xm23_pkg.sv
// Shared XM23 types and widths used across the fetch front end.
package xm23_pkg;
  localparam int INST_W = 16;
  localparam int ADDR_W = 16;
  localparam logic [ADDR_W-1:0] PC_STEP = 16'd2;

  typedef enum logic [1:0] {IDLE, WAIT, DISCARD} fetch_state_t;
endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory read bus: single outstanding req/ack, address held until ack.
interface fetch_stage_if;
  import xm23_pkg::*;

  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [INST_W-1:0] mem_rdata;

  modport master (output mem_req, output mem_addr, input mem_ack, input mem_rdata);
  modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_rdata);
endinterface

// File: rtl/inst_queue.sv
// Small power-of-two FIFO of {addr, data} pairs with synchronous flush.
module inst_queue
  import xm23_pkg::*;
#(
  parameter int QDEPTH = 2,
  parameter int DATA_W = INST_W,
  parameter int TAG_W  = ADDR_W,
  localparam int PTR_W = $clog2(QDEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              flush,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] push_data,
  input  logic [TAG_W-1:0]  push_addr,
  output logic [DATA_W-1:0] head_data,
  output logic [TAG_W-1:0]  head_addr,
  output logic [CNT_W-1:0]  count
);
  logic [DATA_W-1:0] data_mem [QDEPTH];
  logic [TAG_W-1:0]  addr_mem [QDEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Storage carries no reset; emptiness is tracked by count alone.
  always_ff @(posedge clk_in) begin
    if (push && !flush) begin
      data_mem[wr_ptr] <= push_data;
      addr_mem[wr_ptr] <= push_addr;
    end
  end

  assign head_data = data_mem[rd_ptr];
  assign head_addr = addr_mem[rd_ptr];
endmodule

// File: rtl/fetch_stage.sv
// XM23 instruction fetch: PC, single-outstanding memory reads, queue toward decode.
module fetch_stage
  import xm23_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000,
  parameter int                QDEPTH   = 2
) (
  input  logic               clk_in,
  input  logic               reset,
  input  logic               stall,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  fetch_stage_if.master      mem,
  output logic [INST_W-1:0]  inst,
  output logic [ADDR_W-1:0]  inst_pc,
  output logic               inst_valid
);
  localparam int                CNT_W    = $clog2(QDEPTH) + 1;
  localparam logic [ADDR_W-1:0] ALIGN_MK = ~ADDR_W'(1);
  localparam logic [ADDR_W-1:0] PC_INIT  = RESET_PC & ALIGN_MK;

  fetch_state_t      state, state_nxt;
  logic [ADDR_W-1:0] pc, pc_nxt;
  logic              req_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] issue_addr;
  logic              issue;
  logic              acked;
  logic              q_push, q_pop;
  logic [CNT_W-1:0]  q_count, count_after;
  logic [INST_W-1:0] head_data;
  logic [ADDR_W-1:0] head_addr;

  inst_queue #(.QDEPTH(QDEPTH), .DATA_W(INST_W), .TAG_W(ADDR_W)) u_queue (
    .clk_in    (clk_in),
    .reset     (reset),
    .flush     (redirect),
    .push      (q_push),
    .pop       (q_pop),
    .push_data (mem.mem_rdata),
    .push_addr (mem.mem_addr),
    .head_data (head_data),
    .head_addr (head_addr),
    .count     (q_count)
  );

  assign inst_valid = (q_count != '0);
  assign inst       = inst_valid ? head_data : '0;
  assign inst_pc    = inst_valid ? head_addr : '0;

  always_comb begin
    target      = redirect_pc & ALIGN_MK;
    // mem_req is high exactly when not IDLE, so stray acks are masked here.
    acked       = mem.mem_ack && (state != IDLE);
    q_pop       = inst_valid && !stall;
    q_push      = acked && (state == WAIT) && !redirect;
    count_after = q_count + CNT_W'(q_push) - CNT_W'(q_pop);
    state_nxt   = state;
    pc_nxt      = pc;
    req_nxt     = mem.mem_req;
    addr_nxt    = mem.mem_addr;
    issue       = 1'b0;
    issue_addr  = pc;
    unique case (state)
      IDLE: begin
        if (redirect) begin
          issue      = 1'b1;
          issue_addr = target;
        end else if (count_after < CNT_W'(QDEPTH)) begin
          issue = 1'b1;
        end
      end
      WAIT: begin
        if (redirect) begin
          if (acked) begin
            issue      = 1'b1;
            issue_addr = target;
          end else begin
            pc_nxt    = target;
            state_nxt = DISCARD;
          end
        end else if (acked) begin
          if (count_after < CNT_W'(QDEPTH)) begin
            issue = 1'b1;
          end else begin
            req_nxt   = 1'b0;
            state_nxt = IDLE;
          end
        end
      end
      DISCARD: begin
        if (acked) begin
          issue      = 1'b1;
          issue_addr = redirect ? target : pc;
        end else if (redirect) begin
          pc_nxt = target;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (issue) begin
      state_nxt = WAIT;
      req_nxt   = 1'b1;
      addr_nxt  = issue_addr;
      pc_nxt    = issue_addr + PC_STEP;
    end
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      pc           <= PC_INIT;
      mem.mem_req  <= 1'b0;
      mem.mem_addr <= PC_INIT;
    end else begin
      state        <= state_nxt;
      pc           <= pc_nxt;
      mem.mem_req  <= req_nxt;
      mem.mem_addr <= addr_nxt;
    end
  end
endmodule
